// File: rtl/arb_mux.sv
// N:1 arbitrated multiplexer: valid/ready inputs merged onto one registered output slot.
// The grant comes from a round-robin or fixed-priority search over the input requests.
module arb_mux #(
  parameter int WIDTH   = 32,
  parameter int NUM_CH  = 2,
  parameter int RR_MODE = 1,
  localparam int SELW   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SELW-1:0]         out_chan,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SELW-1:0]  rr_ptr_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_chan_r;
  logic             out_valid_r;

  logic             grant_any_s;
  logic [SELW-1:0]  grant_idx_s;
  logic             slot_free_s;
  logic             transfer_s;
  logic [WIDTH-1:0] sel_data_s;
  logic [SELW-1:0]  rr_next_s;

  // Grant search: first request at or after the base index, wrapping; base is 0 for fixed priority
  always_comb begin : grant_search
    int   j;
    logic hit;
    j           = 0;
    hit         = 1'b0;
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j           = k + ((RR_MODE != 0) ? int'(rr_ptr_r) : 0);
      j           = (j >= NUM_CH) ? (j - NUM_CH) : j;
      hit         = in_valid[SELW'(j)] & ~grant_any_s;
      grant_idx_s = hit ? SELW'(j) : grant_idx_s;
      grant_any_s = grant_any_s | hit;
    end
  end

  // Handshake: the slot refills in the same cycle it drains, so out_ready feeds in_ready directly
  always_comb begin
    slot_free_s = ~out_valid_r | out_ready;
    transfer_s  = grant_any_s & slot_free_s;
    in_ready    = '0;
    if (transfer_s) begin
      in_ready[grant_idx_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Data select and next pointer; only the granted slice is read so X elsewhere cannot leak
  always_comb begin
    sel_data_s = in_data[grant_idx_s*WIDTH +: WIDTH];
    rr_next_s  = (grant_idx_s == SELW'(NUM_CH - 1)) ? '0 : (grant_idx_s + 1'b1);
  end

  // Output slot and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_r  <= '0;
      out_chan_r  <= '0;
      out_valid_r <= 1'b0;
      rr_ptr_r    <= '0;
    end else if (transfer_s) begin
      out_data_r  <= sel_data_s;
      out_chan_r  <= grant_idx_s;
      out_valid_r <= 1'b1;
      if (RR_MODE != 0) begin
        rr_ptr_r <= rr_next_s;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_data  = out_data_r;
  assign out_chan  = out_chan_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: a 4-channel round-robin instance and a 4-channel
// fixed-priority instance share the same stimulus.
module tb_arb_mux;

  logic          clk = 1'b0;
  logic          reset;
  logic [127:0]  in_data;
  logic [3:0]    in_valid;
  logic          out_ready;

  logic [3:0]    rr_in_ready;
  logic [31:0]   rr_out_data;
  logic [1:0]    rr_out_chan;
  logic          rr_out_valid;

  logic [3:0]    fp_in_ready;
  logic [31:0]   fp_out_data;
  logic [1:0]    fp_out_chan;
  logic          fp_out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(32), .NUM_CH(4), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rr_in_ready), .out_data(rr_out_data), .out_chan(rr_out_chan),
    .out_valid(rr_out_valid), .out_ready(out_ready)
  );

  arb_mux #(.WIDTH(32), .NUM_CH(4), .RR_MODE(0)) u_fp (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(fp_in_ready), .out_data(fp_out_data), .out_chan(fp_out_chan),
    .out_valid(fp_out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    set_data(32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    #1;
    chk("reset_out_valid", 32'(rr_out_valid), 32'd0);
    chk("reset_out_data", rr_out_data, 32'd0);
    chk("reset_out_chan", 32'(rr_out_chan), 32'd0);
    chk("reset_in_ready", 32'(rr_in_ready), 32'd0);
    reset = 1'b0;
    tick();

    // Round-robin fairness, all four requesting
    set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_in_ready", 32'(rr_in_ready), 32'(4'b0001 << (i % 4)));
      tick();
      chk("rr_out_chan", 32'(rr_out_chan), 32'(i % 4));
      chk("rr_out_data", rr_out_data, 32'hA0 + 32'(i % 4));
      chk("rr_out_valid", 32'(rr_out_valid), 32'd1);
    end

    // Backpressure: A1 buffered, ch2 waits for 5 cycles
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    set_data(32'hA0, 32'hA1, 32'hDEAD_BEEF, 32'hA3);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 32'(rr_in_ready), 32'd0);
      tick();
      chk("bp_out_data", rr_out_data, 32'hA1);
      chk("bp_out_valid", 32'(rr_out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(rr_in_ready), 32'b0100);
    tick();
    chk("bp_new_data", rr_out_data, 32'hDEAD_BEEF);
    chk("bp_new_chan", 32'(rr_out_chan), 32'd2);

    // Idle drain
    in_valid = 4'b0000;
    #1;
    chk("idle_in_ready", 32'(rr_in_ready), 32'd0);
    tick();
    chk("drain_valid", 32'(rr_out_valid), 32'd0);
    chk("drain_data_kept", rr_out_data, 32'hDEAD_BEEF);
    tick();
    chk("drain_valid2", 32'(rr_out_valid), 32'd0);

    // Pointer wrap: pointer is 3 after the ch2 transfer
    set_data(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    in_valid = 4'b1001;
    #1;
    chk("wrap_ready_ch3", 32'(rr_in_ready), 32'b1000);
    tick();
    chk("wrap_chan3", 32'(rr_out_chan), 32'd3);
    in_valid = 4'b0001;
    #1;
    chk("wrap_ready_ch0", 32'(rr_in_ready), 32'b0001);
    tick();
    chk("wrap_chan0", 32'(rr_out_chan), 32'd0);
    chk("wrap_data0", rr_out_data, 32'hC0);
    in_valid = 4'b1000;
    #1;
    chk("lone_ready_ch3", 32'(rr_in_ready), 32'b1000);
    tick();
    chk("lone_chan3", 32'(rr_out_chan), 32'd3);
    chk("lone_data3", rr_out_data, 32'hC3);

    // Reset mid-stream with 0x11 buffered
    set_data(32'h0, 32'h11, 32'h0, 32'h33);
    in_valid = 4'b0010;
    tick();
    chk("pre_reset_data", rr_out_data, 32'h11);
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(rr_out_valid), 32'd0);
    chk("midrst_data", rr_out_data, 32'd0);
    chk("midrst_chan", 32'(rr_out_chan), 32'd0);
    tick();
    reset    = 1'b0;
    in_valid = 4'b1010;
    #1;
    chk("postrst_ready", 32'(rr_in_ready), 32'b0010);
    tick();
    chk("postrst_chan", 32'(rr_out_chan), 32'd1);
    chk("postrst_data", rr_out_data, 32'h11);

    // Fixed priority: ch1 starves ch3 until it drops
    set_data(32'h0, 32'hB1, 32'h0, 32'hB3);
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_in_ready", 32'(fp_in_ready), 32'b0010);
      tick();
      chk("fp_chan1", 32'(fp_out_chan), 32'd1);
      chk("fp_data1", fp_out_data, 32'hB1);
    end
    in_valid = 4'b1000;
    #1;
    chk("fp_ready_ch3", 32'(fp_in_ready), 32'b1000);
    tick();
    chk("fp_chan3", 32'(fp_out_chan), 32'd3);
    chk("fp_data3", fp_out_data, 32'hB3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised N:1 arbitrated multiplexer with valid/ready handshakes and a registered output stage.
- Successor to the plain 2:1 select mux: arbitration logic generates the select internally instead of taking it as an input.
- Merges several requesters onto one shared consumer, e.g. instruction fetch and data access onto a shared memory port, or multiple writeback sources.
- One-cycle latency from accepted input to output.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- NUM_CH, 2, number of input channels; legal range 2..16.
- RR_MODE, 1, arbitration policy: 1 = round-robin; 0 = fixed priority, lowest index wins.
- SELW, derived, $clog2(NUM_CH); not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel request/valid.
- in_ready  output  NUM_CH  per-channel accept; at most one bit high per cycle.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SELW  index of the channel that produced out_data.
- out_valid  output  1  out_data/out_chan hold a word.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, round-robin pointer rr_ptr=0.
- A reset asserted mid-operation discards any buffered word; nothing is replayed.
- Output slot is free when out_valid==0 or out_ready==1 (drain and refill in the same cycle is allowed).
- Grant is combinational from in_valid and rr_ptr:
  - Round-robin: the first asserted in_valid searching from index rr_ptr upward, wrapping NUM_CH-1 -> 0.
  - Fixed priority: the lowest asserted in_valid index; rr_ptr is unused.
- in_ready[g] = grant[g] AND slot_free. All other in_ready bits are 0.
- in_ready is never asserted when no in_valid is high.
- There is a combinational path out_ready -> in_ready.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. On the following edge:
  - out_data <= in_data[g]
  - out_chan <= g
  - out_valid <= 1
  - in round-robin mode, rr_ptr <= (g+1) mod NUM_CH, wrapping to 0 after NUM_CH-1
- No transfer and out_ready==1: out_valid <= 0. out_data and out_chan hold their last values.
- No transfer and out_ready==0: all output registers hold.
- rr_ptr changes only on a transfer.
- While stalled (out_valid=1, out_ready=0), the grant may move to a newly asserted higher-priority channel. No data is lost, because nothing transfers until the slot frees.
- Producers keep in_valid and in_data stable until accepted.
- Throughput: one word per cycle when out_ready is held high. Round-robin guarantees each continuously requesting channel service within NUM_CH transfers.
- Latency: data accepted at edge k appears on out_data after edge k (visible in cycle k+1).
- An X on in_data of non-granted channels must not propagate to out_data.

Test Plan:
- Reset mid-stream: NUM_CH=4, WIDTH=32, out_valid=1 holding 0x11; assert reset between edges -> out_valid, out_data and out_chan drop to 0 immediately; after release, first grant goes to the lowest valid index (rr_ptr=0).
- Round-robin fairness: all 4 channels valid continuously with data 0xA0..0xA3, out_ready=1 -> out_chan sequence 0,1,2,3,0,1,... and out_data 0xA0,0xA1,0xA2,0xA3,0xA0,...; exactly one in_ready high per cycle.
- Fixed priority (RR_MODE=0): channels 1 and 3 continuously valid -> channel 1 always granted and channel 3 starved; drop ch1 valid -> next word has out_chan=3.
- Backpressure: out_ready=0 for 5 cycles with ch2 valid (0xDEAD_BEEF) after one word is already buffered -> in_ready all 0 and out_data stable; raise out_ready -> buffered word drains and 0xDEAD_BEEF is accepted the same cycle, appearing next cycle.
- Pointer wrap and sparse requests: only ch3 then ch0 valid -> after the ch3 transfer rr_ptr=0, ch0 granted next; a later lone ch3 request is granted immediately.
- Idle drain: single word accepted, then in_valid=0 with out_ready=1 -> out_valid high for exactly one cycle, then 0; out_data retains its value.
